lights_out_board: RTL and testbench
===================================

Name: lights_out_board

Overview:
Game-board state generator for the 32-cell "lights out" puzzle. It sits directly upstream of the win checker and drives its 32-bit screen-values input.
- Seeds a solvable random board from an LFSR.
- Moves a player cursor.
- Toggles a plus-shaped cell group on each press.
- Freezes the board once the player has cleared it.

Parameters:
NumberOfBits, 31, index of the top cell; board has NumberOfBits+1 = 32 cells, laid out 4 rows x 8 cols, cell = row*8+col.
SEED_MOVES, 24, random presses applied during seeding; 0 means skip seeding (bench mode).
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
new_game  input  1  level; rising edge restarts the game
btn_left  input  1  debounced, synchronous level
btn_right  input  1  debounced, synchronous level
btn_up  input  1  debounced, synchronous level
btn_down  input  1  debounced, synchronous level
btn_press  input  1  debounced, synchronous level; toggles at cursor
screen_values  output  32  cell state, 1 = lit; feeds win checker
cursor  output  5  current cell index
move_count  output  10  player presses, saturates at 1023
seeding  output  1  high while in SEED

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values: screen_values=0, cursor=0, move_count=0, seeding=1, state=SEED, LFSR=LFSR_SEED, all edge-detect registers=0.
- Edge detection:
  - Each button and new_game has a prev register; edge = level & ~prev.
  - An action fires at the clock edge where edge=1. Its result is visible from the next cycle (1-cycle latency).
  - A held button fires only once.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Steps every cycle in every state except reset.
  - Random index = lfsr[4:0].
- Toggle group of cell c:
  - c itself, plus the orthogonal neighbours up, down, left and right.
  - No wrap at board edges: col 0 has no left neighbour, col 7 no right, row 0 no up, row 3 no down.
  - Group size is 3, 4 or 5 cells. Apply as screen_values ^= mask(c).
- State SEED:
  - Each cycle, apply the toggle group at the random index; count SEED_MOVES cycles.
  - At the end of the count: if the board is all zero, restart the count (stay in SEED); otherwise go to PLAY.
  - If SEED_MOVES=0, go to PLAY on the first cycle with the board at 0.
  - Buttons are ignored in SEED; seeding=1.
- State PLAY:
  - Handles at most one action per cycle, by priority press > left > right > up > down. Lower-priority edges in the same cycle are dropped, not queued.
  - press: toggle group at cursor; move_count += 1 (saturating).
  - left: cursor = cursor-1 mod 32. right: cursor+1 mod 32.
  - up: cursor-8 mod 32. down: cursor+8 mod 32. (Wraps linearly; 0-1 = 31, 3-8 = 27.)
  - Go to SOLVED when screen_values==0 and move_count != 0, evaluated on the registered board (one cycle after the clearing press).
- State SOLVED:
  - screen_values, cursor and move_count hold; all buttons ignored.
- new_game edge, any state (overrides buttons in the same cycle):
  - Next cycle: screen_values=0, cursor=0, move_count=0, state=SEED.
  - LFSR is not reloaded, so the next board differs.
- reset asserted mid-seed or mid-play: all registers take reset values next cycle, with no partial toggle.

Decomposition:
- Package game_pkg:
  - ROWS=4, COLS=8, CELLS=32.
  - State enum {SEED, PLAY, SOLVED}.
  - LFSR tap constant 16'hB400.
  - Pure function toggle_mask(idx) returning 32-bit mask, shared with the win-checker bench model.
- Sub-module lfsr16 (clk, reset, seed param, 16-bit state out).
- Remainder (edge detect, FSM, cursor, board) in one module.

Test Plan:
- Reset with SEED_MOVES=24 -> seeding=1 for exactly 24 cycles, then 0. screen_values equals the bench model of 24 LFSR toggles and is non-zero. cursor=0, move_count=0.
- SEED_MOVES=0; press at cursor 0 -> screen_values=32'h00000103 next cycle, move_count=1. Press again -> 0, move_count=2; SOLVED one cycle later; further presses leave everything unchanged.
- SEED_MOVES=0; right x9 to cursor 9, press -> screen_values=32'h00020702 (cells 1,8,9,10,17). Hold btn_press 10 cycles -> only one toggle.
- Cursor wrap: left at 0 -> 31; right at 31 -> 0; up at 3 -> 27; down at 28 -> 4.
- Same-cycle btn_press and btn_left edges at cursor 5 -> cells 4,5,6,13 toggled, cursor stays 5. Same-cycle new_game and btn_press -> board cleared, SEED entered, no toggle.
- reset pulsed mid-PLAY after 3 presses -> next cycle all outputs at reset values and seeding=1. LFSR restarts from LFSR_SEED, so the identical board is reproduced.

Source files
------------

// File: rtl/lights_out_board_pkg.sv
// rtl/lights_out_board_pkg.sv - shared board geometry, FSM states and toggle-group helper
// Used by the board generator and by win-checker bench models.
package game_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int CELLS = 32;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    PLAY   = 2'd1,
    SOLVED = 2'd2
  } game_state_t;

  // Plus-shaped group around idx; neighbours that fall off the board are dropped.
  function automatic logic [31:0] toggle_mask(input logic [4:0] idx);
    logic [31:0] m;
    m = 32'd1 << idx;
    if (idx[2:0] != 3'd0) m = m | (32'd1 << (idx - 5'd1));
    if (idx[2:0] != 3'd7) m = m | (32'd1 << (idx + 5'd1));
    if (idx[4:3] != 2'd0) m = m | (32'd1 << (idx - 5'd8));
    if (idx[4:3] != 2'd3) m = m | (32'd1 << (idx + 5'd8));
    return m;
  endfunction

endpackage

// File: rtl/lights_out_board_lfsr16.sv
// rtl/lights_out_board_lfsr16.sv - 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1
// Free-running; reloads SEED only on reset.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/lights_out_board.sv
// rtl/lights_out_board.sv - lights-out game board: seeding, cursor, toggles, solved freeze
// Drives the 32-bit screen-values bus consumed by the win checker.
module lights_out_board
  import game_pkg::*;
#(
  parameter int          NumberOfBits = 31,
  parameter int          SEED_MOVES   = 24,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_game,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_press,
  output logic [NumberOfBits:0] screen_values,
  output logic [4:0]            cursor,
  output logic [9:0]            move_count,
  output logic                  seeding
);

  localparam logic [15:0] SEED_LAST = 16'(SEED_MOVES - 1);

  logic [15:0] lfsr_state;
  logic [4:0]  btn_prev;
  logic        new_game_prev;
  logic [4:0]  btn_edge;
  logic        new_game_edge;
  logic [15:0] seed_cnt;
  logic [31:0] seeded_board;
  game_state_t state;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state)
  );

  // Bit order {press, left, right, up, down} matches action priority.
  assign btn_edge      = {btn_press, btn_left, btn_right, btn_up, btn_down} & ~btn_prev;
  assign new_game_edge = new_game & ~new_game_prev;
  assign seeded_board  = screen_values ^ toggle_mask(lfsr_state[4:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev      <= 5'd0;
      new_game_prev <= 1'b0;
      screen_values <= '0;
      cursor        <= 5'd0;
      move_count    <= 10'd0;
      seeding       <= 1'b1;
      seed_cnt      <= 16'd0;
      state         <= SEED;
    end else begin
      btn_prev      <= {btn_press, btn_left, btn_right, btn_up, btn_down};
      new_game_prev <= new_game;
      if (new_game_edge) begin
        screen_values <= '0;
        cursor        <= 5'd0;
        move_count    <= 10'd0;
        seeding       <= 1'b1;
        seed_cnt      <= 16'd0;
        state         <= SEED;
      end else begin
        case (state)
          SEED: begin
            if (SEED_MOVES == 0) begin
              state   <= PLAY;
              seeding <= 1'b0;
            end else begin
              screen_values <= seeded_board;
              if (seed_cnt == SEED_LAST) begin
                seed_cnt <= 16'd0;
                // An all-clear board would be instantly solved, so seed another round.
                if (seeded_board != 32'd0) begin
                  state   <= PLAY;
                  seeding <= 1'b0;
                end
              end else begin
                seed_cnt <= seed_cnt + 16'd1;
              end
            end
          end
          PLAY: begin
            if (screen_values == '0 && move_count != 10'd0) begin
              state <= SOLVED;
            end else if (btn_edge[4]) begin
              screen_values <= screen_values ^ toggle_mask(cursor);
              if (move_count != 10'd1023) move_count <= move_count + 10'd1;
            end else if (btn_edge[3]) begin
              cursor <= cursor - 5'd1;
            end else if (btn_edge[2]) begin
              cursor <= cursor + 5'd1;
            end else if (btn_edge[1]) begin
              cursor <= cursor - 5'd8;
            end else if (btn_edge[0]) begin
              cursor <= cursor + 5'd8;
            end
          end
          SOLVED: begin
          end
          default: begin
            state   <= SEED;
            seeding <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lights_out_board.sv
// tb/tb_lights_out_board.sv - self-checking bench for lights_out_board
// Two instances (24 seed moves and 0) share stimulus and are tracked by a cell-array model.
module tb_lights_out_board;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic new_game = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_press = 1'b0;

  logic [31:0] sv_a, sv_b;
  logic [4:0]  cur_a, cur_b;
  logic [9:0]  mc_a, mc_b;
  logic        seed_a, seed_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lights_out_board #(.SEED_MOVES(24)) dut_a (
    .clk(clk), .reset(reset), .new_game(new_game),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_press(btn_press), .screen_values(sv_a), .cursor(cur_a), .move_count(mc_a),
    .seeding(seed_a)
  );

  lights_out_board #(.SEED_MOVES(0)) dut_b (
    .clk(clk), .reset(reset), .new_game(new_game),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_press(btn_press), .screen_values(sv_b), .cursor(cur_b), .move_count(mc_b),
    .seeding(seed_b)
  );

  // Reference model: phase 0 = seeding, 1 = playing, 2 = solved.
  bit m_cell[2][32];
  int m_cur[2], m_mc[2], m_phase[2], m_cnt[2];
  int m_moves[2] = '{24, 0};
  int m_lfsr = 'hACE1;
  int m_prev[6];

  function automatic void m_toggle(int d, int c);
    int r, col;
    r = c / 8;
    col = c % 8;
    m_cell[d][c] ^= 1'b1;
    if (col > 0) m_cell[d][c-1] ^= 1'b1;
    if (col < 7) m_cell[d][c+1] ^= 1'b1;
    if (r > 0)   m_cell[d][c-8] ^= 1'b1;
    if (r < 3)   m_cell[d][c+8] ^= 1'b1;
  endfunction

  function automatic logic [31:0] m_board(int d);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = m_cell[d][i];
    return b;
  endfunction

  function automatic void m_clear(int d);
    for (int i = 0; i < 32; i++) m_cell[d][i] = 1'b0;
    m_cur[d] = 0; m_mc[d] = 0; m_phase[d] = 0; m_cnt[d] = 0;
  endfunction

  task automatic model_step();
    int lv[6];
    int e[6];
    int idx;
    lv = '{int'(new_game), int'(btn_press), int'(btn_left), int'(btn_right), int'(btn_up), int'(btn_down)};
    if (reset) begin
      for (int d = 0; d < 2; d++) m_clear(d);
      m_lfsr = 'hACE1;
      for (int k = 0; k < 6; k++) m_prev[k] = 0;
      return;
    end
    for (int k = 0; k < 6; k++) begin
      e[k] = lv[k] & ~m_prev[k] & 1;
      m_prev[k] = lv[k];
    end
    idx = m_lfsr % 32;
    for (int d = 0; d < 2; d++) begin
      if (e[0] != 0) begin
        m_clear(d);
      end else if (m_phase[d] == 0) begin
        if (m_moves[d] == 0) begin
          m_phase[d] = 1;
        end else begin
          m_toggle(d, idx);
          m_cnt[d]++;
          if (m_cnt[d] == m_moves[d]) begin
            m_cnt[d] = 0;
            if (m_board(d) != 0) m_phase[d] = 1;
          end
        end
      end else if (m_phase[d] == 1) begin
        if (m_board(d) == 0 && m_mc[d] != 0) m_phase[d] = 2;
        else if (e[1] != 0) begin
          m_toggle(d, m_cur[d]);
          if (m_mc[d] < 1023) m_mc[d]++;
        end
        else if (e[2] != 0) m_cur[d] = (m_cur[d] + 31) % 32;
        else if (e[3] != 0) m_cur[d] = (m_cur[d] + 1) % 32;
        else if (e[4] != 0) m_cur[d] = (m_cur[d] + 24) % 32;
        else if (e[5] != 0) m_cur[d] = (m_cur[d] + 8) % 32;
      end
    end
    m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("a_screen",  sv_a, m_board(0));
    chk("a_cursor",  32'(cur_a), 32'(m_cur[0]));
    chk("a_moves",   32'(mc_a), 32'(m_mc[0]));
    chk("a_seeding", 32'(seed_a), 32'(m_phase[0] == 0));
    chk("b_screen",  sv_b, m_board(1));
    chk("b_cursor",  32'(cur_b), 32'(m_cur[1]));
    chk("b_moves",   32'(mc_b), 32'(m_mc[1]));
    chk("b_seeding", 32'(seed_b), 32'(m_phase[1] == 0));
  endtask

  task automatic pulse(input int which, input int times);
    for (int i = 0; i < times; i++) begin
      case (which)
        0: btn_press = 1'b1;
        1: btn_left  = 1'b1;
        2: btn_right = 1'b1;
        3: btn_up    = 1'b1;
        default: btn_down = 1'b1;
      endcase
      tick();
      {btn_press, btn_left, btn_right, btn_up, btn_down} = 5'd0;
      tick();
    end
  endtask

  logic [31:0] board_first;
  int seed_cycles;

  initial begin
    tick();
    tick();
    chk("reset_screen", sv_a, 32'd0);
    chk("reset_cursor", 32'(cur_a), 32'd0);
    chk("reset_moves", 32'(mc_a), 32'd0);
    chk("reset_seeding", 32'(seed_a), 32'd1);
    reset = 1'b0;

    seed_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      if (seed_a) seed_cycles++;
      tick();
    end
    chk("seed_cycles", 32'(seed_cycles), 32'd24);
    n_checks++;
    assert (sv_a !== 32'd0) else begin
      n_fail++;
      $error("FAIL seed_nonzero: observed %h expected non-zero", sv_a);
    end
    board_first = m_board(0);

    pulse(0, 1);
    chk("press0_screen", sv_b, 32'h00000103);
    chk("press0_moves", 32'(mc_b), 32'd1);
    pulse(0, 1);
    chk("press0b_screen", sv_b, 32'd0);
    chk("press0b_moves", 32'(mc_b), 32'd2);
    pulse(0, 2);
    pulse(2, 1);
    chk("solved_screen", sv_b, 32'd0);
    chk("solved_moves", 32'(mc_b), 32'd2);
    chk("solved_cursor", 32'(cur_b), 32'd0);

    new_game = 1'b1;
    tick();
    chk("ng_seeding", 32'(seed_b), 32'd1);
    new_game = 1'b0;
    tick();
    chk("ng_play", 32'(seed_b), 32'd0);

    pulse(2, 9);
    chk("cursor9", 32'(cur_b), 32'd9);
    btn_press = 1'b1;
    tick();
    chk("press9_screen", sv_b, 32'h00020702);
    repeat (9) tick();
    chk("hold_screen", sv_b, 32'h00020702);
    chk("hold_moves", 32'(mc_b), 32'd1);
    btn_press = 1'b0;
    tick();

    pulse(1, 9);
    pulse(1, 1);
    chk("wrap_left", 32'(cur_b), 32'd31);
    pulse(2, 1);
    chk("wrap_right", 32'(cur_b), 32'd0);
    pulse(2, 3);
    pulse(3, 1);
    chk("wrap_up", 32'(cur_b), 32'd27);
    pulse(2, 1);
    pulse(4, 1);
    chk("wrap_down", 32'(cur_b), 32'd4);

    pulse(2, 1);
    btn_press = 1'b1;
    btn_left  = 1'b1;
    tick();
    btn_press = 1'b0;
    btn_left  = 1'b0;
    tick();
    chk("prio_screen", sv_b, 32'h00022772);
    chk("prio_cursor", 32'(cur_b), 32'd5);

    new_game  = 1'b1;
    btn_press = 1'b1;
    tick();
    chk("ng_press_screen", sv_b, 32'd0);
    chk("ng_press_seeding", 32'(seed_b), 32'd1);
    chk("ng_press_moves", 32'(mc_b), 32'd0);
    new_game  = 1'b0;
    btn_press = 1'b0;
    tick();

    for (int i = 0; i < 500; i++) begin
      btn_press = ($urandom % 4) == 0;
      btn_left  = ($urandom % 4) == 0;
      btn_right = ($urandom % 4) == 0;
      btn_up    = ($urandom % 4) == 0;
      btn_down  = ($urandom % 4) == 0;
      new_game  = ($urandom % 80) == 0;
      tick();
    end
    {btn_press, btn_left, btn_right, btn_up, btn_down, new_game} = 6'd0;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (24) tick();
    chk("reseed_a", sv_a, board_first);
    pulse(0, 1);
    pulse(2, 1);
    pulse(0, 2);
    reset = 1'b1;
    tick();
    chk("midplay_screen", sv_a, 32'd0);
    chk("midplay_cursor", 32'(cur_a), 32'd0);
    chk("midplay_moves", 32'(mc_a), 32'd0);
    chk("midplay_seeding", 32'(seed_a), 32'd1);
    reset = 1'b0;
    repeat (24) tick();
    chk("reseed_again", sv_a, board_first);
    chk("reseed_done", 32'(seed_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
